// File: rtl/bram_arb_pkg.sv
// Shared defaults and types for the BRAM port arbiter.
// Requester ids and commands are sized from these defaults.
package bram_arb_pkg;

    localparam int BRAM_NUM_REQ    = 4;
    localparam int BRAM_DATA_WIDTH = 32;
    localparam int BRAM_ADDR_WIDTH = 12;
    localparam int BRAM_ID_WIDTH   = $clog2(BRAM_NUM_REQ);

    typedef logic [BRAM_ID_WIDTH-1:0] req_id_t;

    typedef struct packed {
        logic                       we;
        logic [BRAM_ADDR_WIDTH-1:0] addr;
        logic [BRAM_DATA_WIDTH-1:0] wdata;
    } bram_cmd_t;

endpackage

// File: rtl/bram_rr_grant.sv
// Combinational round-robin grant: picks the first set request at or
// after the round-robin pointer, wrapping modulo NUM_REQ.
module bram_rr_grant
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ  = BRAM_NUM_REQ,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [ID_WIDTH-1:0] i_rr_ptr,
    input  logic                i_en,
    output logic [NUM_REQ-1:0]  o_grant,
    output logic [ID_WIDTH-1:0] o_grant_idx,
    output logic                o_any_grant
);

    logic [ID_WIDTH-1:0] w_idx;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_grant = 1'b0;
        w_idx       = '0;
        if (i_en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_idx = ID_WIDTH'((int'(i_rr_ptr) + k) % NUM_REQ);
                if (!o_any_grant && i_req[w_idx]) begin
                    o_grant[w_idx] = 1'b1;
                    o_grant_idx    = w_idx;
                    o_any_grant    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between NUM_REQ requesters.
// One registered command per cycle; read data returns 2 cycles after accept, tagged by id.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ    = BRAM_NUM_REQ,
    parameter int DATA_WIDTH = BRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = BRAM_ADDR_WIDTH,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          arb_en,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          bram_ce,
    output logic                          bram_we,
    output logic [ADDR_WIDTH-1:0]         bram_addr,
    output logic [DATA_WIDTH-1:0]         bram_din,
    input  logic [DATA_WIDTH-1:0]         bram_qout,
    output logic                          rsp_valid,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          busy
);

    logic [ID_WIDTH-1:0]   r_rr_ptr;
    logic                  r_ce;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;
    logic                  r_rd_pend;
    logic [ID_WIDTH-1:0]   r_rd_id;
    logic                  r_rsp_valid;
    logic [ID_WIDTH-1:0]   r_rsp_id;

    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_WIDTH-1:0]   w_grant_idx;
    logic                  w_any_grant;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [ID_WIDTH-1:0]   w_ptr_next;

    bram_rr_grant #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_grant (
        .i_req       (req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .i_en        (arb_en),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any_grant (w_any_grant)
    );

    assign w_sel_we    = req_we[w_grant_idx];
    assign w_sel_addr  = req_addr[int'(w_grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_wdata = req_wdata[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign w_ptr_next  = (w_grant_idx == ID_WIDTH'(NUM_REQ-1)) ? '0 : w_grant_idx + 1'b1;

    // Command stage: addr/din keep their last values when idle so the BRAM pins stay quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr  <= '0;
            r_ce      <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_din     <= '0;
            r_rd_pend <= 1'b0;
            r_rd_id   <= '0;
        end else begin
            r_ce      <= w_any_grant;
            r_we      <= w_any_grant & w_sel_we;
            r_rd_pend <= w_any_grant & ~w_sel_we;
            if (w_any_grant) begin
                r_rr_ptr <= w_ptr_next;
                r_addr   <= w_sel_addr;
                r_din    <= w_sel_wdata;
                r_rd_id  <= w_grant_idx;
            end
        end
    end

    // Response stage lines up with the cycle the BRAM presents read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
        end else begin
            r_rsp_valid <= r_rd_pend;
            r_rsp_id    <= r_rd_id;
        end
    end

    assign req_ready = w_grant;
    assign bram_ce   = r_ce;
    assign bram_we   = r_we;
    assign bram_addr = r_addr;
    assign bram_din  = r_din;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = bram_qout;
    assign busy      = r_ce | r_rd_pend | (|req_valid);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural 1-cycle-latency BRAM.
module tb_bram_port_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam int IW = 2;

    logic             clk;
    logic             rst_n;
    logic             arb_en;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_we;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    req_ready;
    logic             bram_ce;
    logic             bram_we;
    logic [AW-1:0]    bram_addr;
    logic [DW-1:0]    bram_din;
    logic [DW-1:0]    bram_qout;
    logic             rsp_valid;
    logic [IW-1:0]    rsp_id;
    logic [DW-1:0]    rsp_data;
    logic             busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    bram_port_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arb_en    (arb_en),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .bram_ce   (bram_ce),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_qout (bram_qout),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first BRAM model, 1-cycle read latency
    always @(posedge clk) begin
        if (bram_ce) begin
            if (bram_we) mem[bram_addr] <= bram_din;
            else         bram_qout <= mem[bram_addr];
        end
    end

    // Driver tasks
    task automatic clear_inputs();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic set_req(input int id, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
        req_valid[id]          = 1'b1;
        req_we[id]             = we;
        req_addr[id*AW +: AW]  = addr;
        req_wdata[id*DW +: DW] = wdata;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        arb_en = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        arb_en = 1'b1;
        clear_inputs();
        bram_qout = '0;
        for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bram_ce, bram_we, bram_addr, bram_din} !== '0) begin
            errors++;
            $display("FAIL reset_cmd: got ce=%0b we=%0b addr=%h din=%h, want all 0",
                     bram_ce, bram_we, bram_addr, bram_din);
        end
        checks++;
        if ({rsp_valid, rsp_id, req_ready, busy} !== '0) begin
            errors++;
            $display("FAIL reset_rsp: got rsp_valid=%0b rsp_id=%0d ready=%b busy=%0b, want 0",
                     rsp_valid, rsp_id, req_ready, busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        @(negedge clk);
        set_req(1, 1'b0, 12'h010, '0);
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL rmr_grant: got %b want 0010", req_ready);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (bram_ce !== 1'b1 || bram_addr !== 12'h010) begin
            errors++;
            $display("FAIL rmr_cmd: got ce=%0b addr=%h want ce=1 addr=010", bram_ce, bram_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bram_ce, bram_we, bram_addr, bram_din, rsp_valid, rsp_id} !== '0) begin
            errors++;
            $display("FAIL rmr_async: got ce=%0b addr=%h rsp_valid=%0b, want 0",
                     bram_ce, bram_addr, rsp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || bram_ce !== 1'b0) begin
                errors++;
                $display("FAIL rmr_no_rsp: cycle %0d got rsp_valid=%0b ce=%0b want 0",
                         k, rsp_valid, bram_ce);
            end
        end
    endtask

    task automatic test_single_read();
        apply_reset();
        mem[12'h123] = 32'hDEADBEEF;
        @(negedge clk);
        set_req(2, 1'b0, 12'h123, '0);
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL sr_grant: got %b want 0100", req_ready);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (bram_ce !== 1'b1 || bram_we !== 1'b0 || bram_addr !== 12'h123) begin
            errors++;
            $display("FAIL sr_cmd: got ce=%0b we=%0b addr=%h want 1/0/123",
                     bram_ce, bram_we, bram_addr);
        end
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL sr_early: got rsp_valid=%0b at T+1 want 0", rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sr_rsp: got v=%0b id=%0d data=%h want 1/2/deadbeef",
                     rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || bram_ce !== 1'b0) begin
            errors++;
            $display("FAIL sr_idle: got v=%0b busy=%0b ce=%0b want 0", rsp_valid, busy, bram_ce);
        end
    endtask

    task automatic test_full_contention();
        logic [NR-1:0] exp_ready;
        apply_reset();
        for (int i = 0; i < NR; i++) mem[i] = 32'hC0DE_0000 + i;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            clear_inputs();
            if (k < 8) for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(i), '0);
            #1;
            if (k < 8) begin
                exp_ready = 4'b0001 << (k % NR);
                checks++;
                if (req_ready !== exp_ready) begin
                    errors++;
                    $display("FAIL fc_grant: cycle %0d got %b want %b", k, req_ready, exp_ready);
                end
            end
            if (k >= 1 && k <= 8) begin
                checks++;
                if (bram_ce !== 1'b1 || bram_addr !== AW'((k-1) % NR)) begin
                    errors++;
                    $display("FAIL fc_cmd: cycle %0d got ce=%0b addr=%h want 1/%0h",
                             k, bram_ce, bram_addr, (k-1) % NR);
                end
            end
            if (k >= 2) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== IW'((k-2) % NR) ||
                    rsp_data !== 32'hC0DE_0000 + DW'((k-2) % NR)) begin
                    errors++;
                    $display("FAIL fc_rsp: cycle %0d got v=%0b id=%0d data=%h want 1/%0d",
                             k, rsp_valid, rsp_id, rsp_data, (k-2) % NR);
                end
            end
        end
    endtask

    task automatic test_wrap_skip();
        logic [NR-1:0] exp_seq [4];
        apply_reset();
        exp_seq[0] = 4'b0100;
        exp_seq[1] = 4'b1000;
        exp_seq[2] = 4'b0010;
        exp_seq[3] = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            clear_inputs();
            if (k == 0) begin
                set_req(2, 1'b1, 12'h200, 32'h2);
            end else begin
                set_req(1, 1'b1, 12'h100, 32'h1);
                set_req(3, 1'b1, 12'h300, 32'h3);
            end
            #1;
            checks++;
            if (req_ready !== exp_seq[k]) begin
                errors++;
                $display("FAIL ws_grant: step %0d got %b want %b", k, req_ready, exp_seq[k]);
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_write_then_read();
        apply_reset();
        mem[12'h7FF] = 32'hFFFF_FFFF;
        @(negedge clk);
        set_req(0, 1'b1, 12'h7FF, 32'h0A5A5A5A);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL wr_grant_w: got %b want 0001", req_ready);
        end
        @(negedge clk);
        clear_inputs();
        set_req(1, 1'b0, 12'h7FF, '0);
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL wr_grant_r: got %b want 0010", req_ready);
        end
        checks++;
        if (bram_ce !== 1'b1 || bram_we !== 1'b1 || bram_addr !== 12'h7FF ||
            bram_din !== 32'h0A5A5A5A) begin
            errors++;
            $display("FAIL wr_wcmd: got ce=%0b we=%0b addr=%h din=%h want 1/1/7ff/0a5a5a5a",
                     bram_ce, bram_we, bram_addr, bram_din);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (bram_ce !== 1'b1 || bram_we !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_rcmd: got ce=%0b we=%0b rsp_valid=%0b want 1/0/0",
                     bram_ce, bram_we, rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'h0A5A5A5A) begin
            errors++;
            $display("FAIL wr_rsp: got v=%0b id=%0d data=%h want 1/1/0a5a5a5a",
                     rsp_valid, rsp_id, rsp_data);
        end
    endtask

    task automatic test_arb_en_gating();
        apply_reset();
        @(negedge clk);
        set_req(1, 1'b1, 12'h011, 32'h11);
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL ag_pre: got %b want 0010", req_ready);
        end
        @(negedge clk);
        clear_inputs();
        arb_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(12'h040 + i), '0);
            #1;
            checks++;
            if (req_ready !== 4'b0000 || bram_ce !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL ag_gated: cycle %0d got ready=%b ce=%0b busy=%0b want 0/0/1",
                         k, req_ready, bram_ce, busy);
            end
        end
        @(negedge clk);
        arb_en = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL ag_resume: got %b want 0100", req_ready);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (bram_ce !== 1'b1 || bram_addr !== 12'h042) begin
            errors++;
            $display("FAIL ag_cmd: got ce=%0b addr=%h want 1/042", bram_ce, bram_addr);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_read();
        test_single_read();
        test_full_contention();
        test_wrap_skip();
        test_write_then_read();
        test_arb_en_gating();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
